// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Default VGA timing constants, counter type and phase encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_cnt_w   = 11;
    localparam int c_cnt_max = (1 << c_cnt_w) - 1;

    typedef logic [c_cnt_w-1:0] cnt_t;

    localparam int c_h_visible = 800;
    localparam int c_h_front   = 40;
    localparam int c_h_sync    = 48;
    localparam int c_h_back    = 88;
    localparam int c_v_visible = 480;
    localparam int c_v_front   = 13;
    localparam int c_v_sync    = 3;
    localparam int c_v_back    = 32;

    function automatic int axis_total(input int vis, input int fp, input int sy, input int bp);
        return vis + fp + sy + bp;
    endfunction

    localparam int c_h_total = axis_total(c_h_visible, c_h_front, c_h_sync, c_h_back);
    localparam int c_v_total = axis_total(c_v_visible, c_v_front, c_v_sync, c_v_back);

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_t;

    // Phase advance evaluated against the counter value about to be loaded,
    // so the registered phase always matches the registered count.
    function automatic phase_t phase_step(input phase_t cur, input cnt_t nxt,
                                          input cnt_t front_at, input cnt_t sync_at,
                                          input cnt_t back_at);
        phase_t res;
        res = cur;
        case (cur)
            PH_VISIBLE: if (nxt == front_at) res = PH_FRONT;
            PH_FRONT:   if (nxt == sync_at)  res = PH_SYNC;
            PH_SYNC:    if (nxt == back_at)  res = PH_BACK;
            PH_BACK:    if (nxt == '0)       res = PH_VISIBLE;
            default:    res = PH_VISIBLE;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_delay.sv
// ============================================================================
//  Module      : sync_delay
//  Description : N-deep, W-wide shift register with asynchronous reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_delay #(
    parameter int             N         = 2,
    parameter int             W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_stage [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[N-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
//  Module      : vga_timing
//  Description : VGA raster counters, sync/DE generation and pixel alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE     = c_h_visible,
    parameter int   H_FRONT       = c_h_front,
    parameter int   H_SYNC        = c_h_sync,
    parameter int   H_BACK        = c_h_back,
    parameter int   V_VISIBLE     = c_v_visible,
    parameter int   V_FRONT       = c_v_front,
    parameter int   V_SYNC        = c_v_sync,
    parameter int   V_BACK        = c_v_back,
    parameter logic SYNC_POL      = 1'b0,
    parameter int   PIXEL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pixel_in,
    output logic [10:0] vga_h,
    output logic [10:0] vga_v,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [2:0]  rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    generate
        if (H_TOTAL > c_cnt_max || V_TOTAL > c_cnt_max) begin : g_bad_total
            $error("vga_timing: H_TOTAL/V_TOTAL exceed 11-bit counter range");
        end
        if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4) begin : g_bad_latency
            $error("vga_timing: PIXEL_LATENCY must be within 1..4");
        end
    endgenerate

    localparam cnt_t c_h_last     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t c_v_last     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t c_h_front_at = cnt_t'(H_VISIBLE);
    localparam cnt_t c_h_sync_at  = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t c_h_back_at  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t c_v_front_at = cnt_t'(V_VISIBLE);
    localparam cnt_t c_v_sync_at  = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t c_v_back_at  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    cnt_t   r_h_cnt, r_v_cnt;
    cnt_t   w_h_nxt, w_v_nxt;
    logic   w_h_wrap;
    phase_t r_h_state, r_v_state;
    phase_t w_h_state_nxt, w_v_state_nxt;

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + cnt_t'(1);
    assign w_v_nxt  = !w_h_wrap             ? r_v_cnt :
                      (r_v_cnt == c_v_last) ? '0      : r_v_cnt + cnt_t'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_h_state <= PH_VISIBLE;
            r_v_state <= PH_VISIBLE;
        end else begin
            r_h_cnt   <= w_h_nxt;
            r_v_cnt   <= w_v_nxt;
            r_h_state <= w_h_state_nxt;
            r_v_state <= w_v_state_nxt;
        end
    end

    always_comb begin
        w_h_state_nxt = r_h_state;
        w_v_state_nxt = r_v_state;
        w_h_state_nxt = phase_step(r_h_state, w_h_nxt, c_h_front_at, c_h_sync_at, c_h_back_at);
        if (w_h_wrap) begin
            w_v_state_nxt = phase_step(r_v_state, w_v_nxt, c_v_front_at, c_v_sync_at, c_v_back_at);
        end
    end

    logic       w_de, w_hs, w_vs;
    logic [2:0] w_dly;

    assign w_de = (r_h_state == PH_VISIBLE) && (r_v_state == PH_VISIBLE);
    assign w_hs = (r_h_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign w_vs = (r_v_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;

    // Delay matches the frame-buffer read latency so controls meet their pixel.
    sync_delay #(
        .N         (PIXEL_LATENCY),
        .W         (3),
        .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_align (
        .clk    (clk),
        .rst    (reset),
        .i_data ({w_hs, w_vs, w_de}),
        .o_data (w_dly)
    );

    logic       r_hsync, r_vsync, r_de;
    logic [2:0] r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
            r_rgb   <= 3'b000;
        end else begin
            r_hsync <= w_dly[2];
            r_vsync <= w_dly[1];
            r_de    <= w_dly[0];
            r_rgb   <= w_dly[0] ? pixel_in : 3'b000;
        end
    end

    assign vga_h       = r_h_cnt;
    assign vga_v       = r_v_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign rgb         = r_rgb;
    assign frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: H_VISIBLE 800 active pixels per line; H_FRONT 40 h front porch; H_SYNC 48 h sync width; H_BACK 88 h back porch; V_VISIBLE 480 active lines; V_FRONT 13 v front porch; V_SYNC 3 v sync width; V_BACK 32 v back porch; SYNC_POL 0 sync active level; PIXEL_LATENCY 2 clocks from vga_h/vga_v to valid pixel_in (range 1..4).
REQ-002 clk  in  1  pixel clock, the single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pixel_in  in  3  RGB pixel from the frame buffer for the coordinate issued PIXEL_LATENCY clocks earlier.
REQ-005 vga_h  out  11  current horizontal count, 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (976).
REQ-006 vga_v  out  11  current vertical count, 0..V_TOTAL-1, where V_TOTAL = sum of the four V parameters (528).
REQ-007 hsync  out  1  horizontal sync, delay-aligned to rgb.
REQ-008 vsync  out  1  vertical sync, delay-aligned to rgb.
REQ-009 de  out  1  display enable, delay-aligned to rgb.
REQ-010 rgb  out  3  pixel to the DAC; 3'b000 whenever de=0.
REQ-011 frame_start  out  1  one-clock pulse when vga_h=0 and vga_v=0 are presented (undelayed).

Function
REQ-012 vga_h SHALL increment by 1 each clock and wrap from H_TOTAL-1 to 0.
REQ-013 vga_v SHALL increment by 1 only in the clock where vga_h wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same clock.
REQ-014 Each axis SHALL run a 4-state phase FSM: VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE, with each transition taken when the axis counter reaches the phase boundary (H: 800/840/888/976; V: 480/493/496/528).
REQ-015 Undelayed de SHALL be (h phase VISIBLE) AND (v phase VISIBLE).
REQ-016 Undelayed hsync SHALL equal SYNC_POL while the h phase is SYNC and ~SYNC_POL otherwise; vsync SHALL follow the same rule on the v phase, with no dependency on the h position.
REQ-017 hsync, vsync and de SHALL pass through a PIXEL_LATENCY-deep shift register so that they change on the same clock edge as the rgb of their coordinate.
REQ-018 rgb SHALL be registered as pixel_in when the delayed de is 1, else 3'b000; total latency from a coordinate to its rgb is PIXEL_LATENCY+1 clocks.
REQ-019 The hsync, vsync and de outputs SHALL be registered in the same stage as rgb.
REQ-020 Counter arithmetic SHALL be 11-bit unsigned; with the defaults no value exceeds 975, so no overflow is possible.
REQ-021 A parameter set with H_TOTAL or V_TOTAL > 2047 SHALL be rejected at elaboration.
REQ-022 frame_start SHALL be combinational from the counters (vga_h==0 && vga_v==0), exactly one pulse per frame.

Reset
REQ-023 While reset=1: vga_h=0, vga_v=0, both FSMs in VISIBLE, the delay lines filled with de=0 and hsync=vsync=~SYNC_POL, rgb=3'b000, de=0, and hsync/vsync=~SYNC_POL.
REQ-024 Reset asserted mid-line or mid-frame SHALL take effect immediately and asynchronously, with no partial sync pulse emitted afterwards.
REQ-025 After reset deasserts, the first rising edge SHALL advance vga_h from 0 to 1; frame_start SHALL be high during reset release.

Structure
REQ-026 The default timing constants, the derived H_TOTAL/V_TOTAL and the phase-state encoding (VISIBLE=0, FRONT=1, SYNC=2, BACK=3) SHALL live in a shared package vga_pkg.
REQ-027 One sub-module, sync_delay (a parameterised N-deep, W-wide shift register with async reset value), SHALL implement the alignment pipeline.
REQ-028 There SHALL be no other sub-modules.

Verification
REQ-029 Reset release, then 976 clocks: vga_h sequence 0..975,0; vga_v goes 0->1 exactly at the wrap; frame_start is high only in cycle 0.
REQ-030 Full frame: delayed de is high for exactly 800x480 = 384000 clocks; hsync is low for 48 clocks starting at delayed h=840; vsync is low for 3 full lines starting at line 493 (SYNC_POL=0).
REQ-031 Drive pixel_in = vga_h[2:0] delayed by 2: rgb at output coordinate (h,v) equals h[2:0] inside the visible area and 3'b000 at h=800..975.
REQ-032 Reset pulsed at h=860, v=200 (inside hsync): hsync goes high and rgb goes to 0 asynchronously; restart is clean from (0,0) with no runt pulse.
REQ-033 Run 3 frames with PIXEL_LATENCY=1 and then =4: the de rising edge lags vga_h=0 by PIXEL_LATENCY+1 clocks in each case.
